memory_access_unit: RTL and testbench

//  Load/store unit for the Memory stage. Sits directly downstream of the Execute->Memory pipeline register.

---
 rtl/memory_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - Memory-stage load/store unit with req/ack data port (optional MEM_TIMEOUT_EN)
module memory_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ValidM,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  DmemReq,
  output logic                  DmemWe,
  output logic [DATA_WIDTH-1:0] DmemAddr,
  output logic [DATA_WIDTH-1:0] DmemWData,
  output logic [3:0]            DmemByteEn,
  input  logic                  DmemAck,
  input  logic [DATA_WIDTH-1:0] DmemRData,
  output logic [DATA_WIDTH-1:0] LoadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                r_state, w_next;
  logic                  r_req, r_we, r_misalign;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_load;
  logic [3:0]            r_be;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;

  logic                  w_access, w_store, w_illegal, w_misal, w_fault, w_go, w_timeout;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_load_ext;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_cfg;

  // Access decode: a store takes priority when both read and write are flagged
  assign w_access = ValidM & (MemReadM | MemWriteM);
  assign w_store  = MemWriteM;
  assign w_illegal = w_store ? (Funct3M[2] | (Funct3M[1:0] == 2'b11))
                             : ((Funct3M == 3'b011) | (Funct3M == 3'b110) | (Funct3M == 3'b111));
  assign w_misal  = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                    ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
  assign w_fault  = w_access & (w_illegal | w_misal);
  assign w_go     = (r_state == IDLE) & w_access & ~w_fault;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);

  // Byte-lane enables and replicated store data for the requested size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << ALUResultM[1:0];
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned read word
  always_comb begin
    w_byte     = DmemRData[8*r_off +: 8];
    w_half     = r_off[1] ? DmemRData[31:16] : DmemRData[15:0];
    w_load_ext = DmemRData;
    case (r_f3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = DmemRData;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_buserr;

  assign w_timeout = (r_state == BUSY) & ~DmemAck & (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign BusErrM   = r_buserr;

  // BUSY-cycle counter and one-cycle bus error pulse on expiry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt    <= 8'd0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= w_timeout;
      if (w_go)
        r_cnt <= 8'd0;
      else if (r_state == BUSY)
        r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign BusErrM   = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state: DONE always returns to IDLE so the held op is not re-issued
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = BUSY;
      BUSY:    if (DmemAck | w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: stall from accept through the last BUSY cycle, never during reset
  always_comb begin
    StallM = 1'b0;
    case (r_state)
      IDLE:    StallM = w_go;
      BUSY:    StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
    StallM = StallM & RST_N;
  end

  // Request/data registers: captured on accept, held through BUSY
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      r_load     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == IDLE) & w_fault;
      if (w_go) begin
        r_req   <= 1'b1;
        r_we    <= w_store;
        r_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_f3    <= Funct3M;
        r_off   <= ALUResultM[1:0];
      end else if (r_state == BUSY) begin
        if (DmemAck) begin
          r_req <= 1'b0;
          if (!r_we) r_load <= w_load_ext;
        end else if (w_timeout) begin
          r_req <= 1'b0;
        end
      end
    end
  end

  assign DmemReq    = r_req;
  assign DmemWe     = r_we;
  assign DmemAddr   = r_addr;
  assign DmemWData  = r_wdata;
  assign DmemByteEn = r_be;
  assign LoadDataM  = r_load;
  assign MisalignM  = r_misalign;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - directed self-checking bench for memory_access_unit
module tb_memory_access_unit;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ValidM, MemWriteM, MemReadM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        DmemReq, DmemWe;
  logic [31:0] DmemAddr, DmemWData;
  logic [3:0]  DmemByteEn;
  logic        DmemAck;
  logic [31:0] DmemRData;
  logic [31:0] LoadDataM;
  logic        StallM, MisalignM, BusErrM;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_buserr, cap_req_done;
  int          stall_cycles;

  always #5 CLK = ~CLK;

  memory_access_unit dut (
    .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWData(DmemWData),
    .DmemByteEn(DmemByteEn), .DmemAck(DmemAck), .DmemRData(DmemRData),
    .LoadDataM(LoadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ValidM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0;
    Funct3M = 3'b000; ALUResultM = 32'd0; WriteDataM = 32'd0;
    DmemAck = 1'b0; DmemRData = 32'd0;
  endtask

  // ack_wait = BUSY cycle (1-based) in which ack is given; 0 = never ack
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_wait, input logic [31:0] rdata);
    int busy;
    @(posedge CLK); #1;
    ValidM = 1'b1; MemWriteM = we; MemReadM = ~we; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wdata;
    stall_cycles = 0; busy = 0; cap_buserr = 1'b0; cap_req_done = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (DmemReq) begin
        busy++;
        if (busy == 1) begin
          cap_addr = DmemAddr; cap_wdata = DmemWData; cap_be = DmemByteEn; cap_we = DmemWe;
        end
        DmemAck   = (ack_wait != 0) && (busy == ack_wait);
        DmemRData = rdata;
      end else begin
        DmemAck = 1'b0;
      end
      if (StallM) stall_cycles++;
      else begin
        cap_buserr   = BusErrM;
        cap_req_done = DmemReq;
        break;
      end
    end
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic fault_op(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge CLK); #1;
    ValidM = 1'b1; MemWriteM = we; MemReadM = ~we; Funct3M = f3; ALUResultM = addr;
    @(negedge CLK);
    check({tag, " stall"}, {31'd0, StallM}, 32'd0);
    check({tag, " req0"}, {31'd0, DmemReq}, 32'd0);
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    check({tag, " misalign pulse"}, {31'd0, MisalignM}, 32'd1);
    check({tag, " req1"}, {31'd0, DmemReq}, 32'd0);
    @(negedge CLK);
    check({tag, " misalign clear"}, {31'd0, MisalignM}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    RST_N = 1'b0;
    ValidM = 1'b1; MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100;
    @(negedge CLK);
    check("rst stall forced low", {31'd0, StallM}, 32'd0);
    check("rst req", {31'd0, DmemReq}, 32'd0);
    check("rst be", {28'd0, DmemByteEn}, 32'd0);
    check("rst load", LoadDataM, 32'd0);
    check("rst misalign", {31'd0, MisalignM}, 32'd0);
    check("rst buserr", {31'd0, BusErrM}, 32'd0);
    idle_inputs();
    @(posedge CLK); #1; RST_N = 1'b1;

    // 1. LW, ack in second BUSY cycle
    run_op(1'b0, 3'b010, 32'h100, 32'd0, 2, 32'hDEADBEEF);
    check("lw addr", cap_addr, 32'h100);
    check("lw be", {28'd0, cap_be}, 32'h0000000F);
    check("lw we", {31'd0, cap_we}, 32'd0);
    check("lw stall cycles", stall_cycles, 32'd3);
    check("lw req low in done", {31'd0, cap_req_done}, 32'd0);
    check("lw data", LoadDataM, 32'hDEADBEEF);
    @(negedge CLK);
    check("lw not reissued", {31'd0, DmemReq}, 32'd0);

    // 2. LB / LBU upper lane
    run_op(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80123456);
    check("lb addr", cap_addr, 32'h100);
    check("lb be", {28'd0, cap_be}, 32'h00000008);
    check("lb stall cycles", stall_cycles, 32'd2);
    check("lb data", LoadDataM, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h80123456);
    check("lbu data", LoadDataM, 32'h00000080);

    // 3. SH upper half
    run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF);
    check("sh we", {31'd0, cap_we}, 32'd1);
    check("sh addr", cap_addr, 32'h200);
    check("sh be", {28'd0, cap_be}, 32'h0000000C);
    check("sh wdata", cap_wdata, 32'hABCDABCD);
    check("sh stall cycles", stall_cycles, 32'd4);
    check("sh load unchanged", LoadDataM, 32'h00000080);

    // extra lanes and sizes
    run_op(1'b1, 3'b000, 32'h001, 32'h7777775A, 1, 32'd0);
    check("sb be", {28'd0, cap_be}, 32'h00000002);
    check("sb wdata", cap_wdata, 32'h5A5A5A5A);
    run_op(1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 1, 32'd0);
    check("sw be", {28'd0, cap_be}, 32'h0000000F);
    check("sw wdata", cap_wdata, 32'hCAFEF00D);
    run_op(1'b0, 3'b001, 32'h102, 32'd0, 1, 32'h80010000);
    check("lh data", LoadDataM, 32'hFFFF8001);
    run_op(1'b0, 3'b101, 32'h100, 32'd0, 1, 32'h1234F00F);
    check("lhu data", LoadDataM, 32'h0000F00F);
    run_op(1'b0, 3'b000, 32'h101, 32'd0, 1, 32'h00007F00);
    check("lb pos data", LoadDataM, 32'h0000007F);

    // 4. faults
    fault_op("lw misaligned", 1'b0, 3'b010, 32'h101);
    fault_op("lh misaligned", 1'b0, 3'b001, 32'h103);
    fault_op("store bad f3", 1'b1, 3'b100, 32'h100);
    fault_op("load bad f3", 1'b0, 3'b011, 32'h100);
    check("fault load unchanged", LoadDataM, 32'h0000007F);

    // 5. reset while BUSY
    @(posedge CLK); #1;
    ValidM = 1'b1; MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
    @(negedge CLK);
    @(negedge CLK);
    check("busy req before rst", {31'd0, DmemReq}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("mid rst req", {31'd0, DmemReq}, 32'd0);
    check("mid rst stall", {31'd0, StallM}, 32'd0);
    check("mid rst addr", DmemAddr, 32'd0);
    check("mid rst load", LoadDataM, 32'd0);
    check("mid rst be", {28'd0, DmemByteEn}, 32'd0);
    @(posedge CLK); #1;
    idle_inputs();
    RST_N = 1'b1;
    @(negedge CLK);
    check("post rst idle req", {31'd0, DmemReq}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // 6. no ack: 64 BUSY cycles then BusErrM with stall released
    run_op(1'b0, 3'b010, 32'h400, 32'd0, 0, 32'd0);
    check("timeout stall cycles", stall_cycles, 32'd65);
    check("timeout buserr", {31'd0, cap_buserr}, 32'd1);
    check("timeout req dropped", {31'd0, cap_req_done}, 32'd0);
    check("timeout load unchanged", LoadDataM, 32'd0);
    @(negedge CLK);
    check("buserr one cycle", {31'd0, BusErrM}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
